div_share_sched: RTL and testbench



---
 rtl/div_share_sched_pkg.sv | 13 +
 rtl/div_share_sched_rr_pick.sv | 27 ++
 rtl/div_share_sched.sv | 157 +++++++++++++++
 tb/tb_div_share_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_share_sched_pkg.sv
// Shared definitions for the divider-sharing scheduler: FSM encoding and default timeout.
package div_share_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2,
    StGap   = 2'd3
  } state_e;

  localparam int unsigned DefTimeoutCyc = 1024;

endpackage

// File: rtl/div_share_sched_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr_i, wrapping around.
module div_share_sched_rr_pick #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [IdxW-1:0]   grant_o,
  output logic              valid_o
);

  always_comb begin
    int unsigned j;
    grant_o = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      j = 32'(ptr_i) + i;
      if (j >= NumReq) j = j - NumReq;
      if (!valid_o && req_i[IdxW'(j)]) begin
        valid_o = 1'b1;
        grant_o = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/div_share_sched.sv
// Round-robin scheduler sharing one sequential divider among NUM_REQ requesters.
// Optional: define DIV_ZERO_GUARD_EN to answer divide-by-zero without starting the divider.
module div_share_sched
  import div_share_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DIVIDEND_W  = 32,
  parameter int unsigned DIVISOR_W   = 16,
  parameter int unsigned QUOT_W      = 16,
  parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DIVIDEND_W-1:0] i_dividend,
  input  logic [NUM_REQ*DIVISOR_W-1:0]  i_divisor,
  output logic [NUM_REQ-1:0]            o_ack,
  output logic [QUOT_W-1:0]             o_quotient,
  output logic                          o_err,
  output logic                          o_busy,
  output logic                          o_div_start,
  output logic [DIVIDEND_W-1:0]         o_div_dividend,
  output logic [DIVISOR_W-1:0]          o_div_divisor,
  input  logic [QUOT_W-1:0]             i_div_quotient,
  input  logic                          i_div_done
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  state_e                state_q, state_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [IdxW-1:0]       grant_q, grant_d;
  logic [DIVIDEND_W-1:0] dividend_q, dividend_d;
  logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [QUOT_W-1:0]     quot_q, quot_d;
  logic                  err_q, err_d;

  logic [IdxW-1:0]       pick_idx;
  logic                  pick_valid;
  logic [DIVIDEND_W-1:0] sel_dividend;
  logic [DIVISOR_W-1:0]  sel_divisor;
  logic                  zero_div;

  div_share_sched_rr_pick #(
    .NumReq (NUM_REQ),
    .IdxW   (IdxW)
  ) u_rr_pick (
    .req_i   (i_req),
    .ptr_i   (ptr_q),
    .grant_o (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (IdxW'(n) == pick_idx) begin
        sel_dividend = i_dividend[n*DIVIDEND_W +: DIVIDEND_W];
        sel_divisor  = i_divisor[n*DIVISOR_W +: DIVISOR_W];
      end
    end
  end

`ifdef DIV_ZERO_GUARD_EN
  assign zero_div = (sel_divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    cnt_d      = cnt_q;
    quot_d     = quot_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          if (zero_div) begin
            // Answer immediately; the divider never sees this request.
            quot_d  = '1;
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            dividend_d = sel_dividend;
            divisor_d  = sel_divisor;
            state_d    = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d = cnt_q + 1'b1;
        if (i_div_done) begin
          quot_d  = i_div_quotient;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          quot_d  = '1;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        ptr_d   = (grant_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = StGap;
      end
      StGap: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      grant_q    <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      cnt_q      <= '0;
      quot_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      cnt_q      <= cnt_d;
      quot_q     <= quot_d;
      err_q      <= err_d;
    end
  end

  // Outputs decode from state so reset clears start/busy without waiting for a clock.
  always_comb begin
    o_ack = '0;
    if (state_q == StResp) o_ack[grant_q] = 1'b1;
  end

  assign o_quotient     = (state_q == StResp) ? quot_q : '0;
  assign o_err          = (state_q == StResp) ? err_q : 1'b0;
  assign o_busy         = (state_q != StIdle);
  assign o_div_start    = (state_q == StIssue);
  assign o_div_dividend = dividend_q;
  assign o_div_divisor  = divisor_q;

endmodule

// File: tb/tb_div_share_sched.sv
// Scoreboard bench for div_share_sched with a behavioural divider model.
module tb_div_share_sched;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int VW  = 16;
  localparam int QW  = 16;
  localparam int TO  = 24;
  localparam int LAT = 18;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  dvd;
  logic [NR*VW-1:0]  dvs;
  logic [NR-1:0]     ack;
  logic [QW-1:0]     quot;
  logic              err;
  logic              busy;
  logic              div_start;
  logic [DW-1:0]     div_dividend;
  logic [VW-1:0]     div_divisor;
  logic [QW-1:0]     div_quot;
  logic              div_done;
  logic [DW-1:0]     div_full;

  div_share_sched #(
    .NUM_REQ     (NR),
    .DIVIDEND_W  (DW),
    .DIVISOR_W   (VW),
    .QUOT_W      (QW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req          (req),
    .i_dividend     (dvd),
    .i_divisor      (dvs),
    .o_ack          (ack),
    .o_quotient     (quot),
    .o_err          (err),
    .o_busy         (busy),
    .o_div_start    (div_start),
    .o_div_dividend (div_dividend),
    .o_div_divisor  (div_divisor),
    .i_div_quotient (div_quot),
    .i_div_done     (div_done)
  );

  typedef struct {
    int          idx;
    logic [15:0] q;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int   low_runs[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   dcnt;
  logic hang;
  int   ack_cyc, done_cyc, rise_cyc, last_run, run, low_run, rise_cnt, acks_seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: done on the LAT-th cycle of start high unless hung.
  always @(posedge clk or posedge rst) begin
    if (rst) dcnt <= 0;
    else     dcnt <= div_start ? dcnt + 1 : 0;
  end

  assign div_full = (div_divisor == '0) ? '1 : div_dividend / {16'h0, div_divisor};
  assign div_quot = div_full[QW-1:0];
  assign div_done = div_start && !hang && (dcnt == LAT - 1);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_op(input int n, input logic [31:0] a, input logic [15:0] b);
    dvd[n*DW +: DW] = a;
    dvs[n*VW +: VW] = b;
  endtask

  task automatic expect_ack(input int n, input logic [15:0] q, input logic e);
    exp_t x;
    x.idx = n;
    x.q   = q;
    x.e   = e;
    sb.push_back(x);
  endtask

  // Waits for n acks, dropping each acked request; rearm bits re-request one cycle later.
  task automatic run_acks(input int n, input logic [NR-1:0] rearm);
    int            got;
    int            t;
    logic [NR-1:0] pend;
    logic [NR-1:0] armed;
    got   = 0;
    t     = 0;
    pend  = '0;
    armed = rearm;
    while (got < n && t < 400) begin
      @(negedge clk);
      t++;
      req  = req | pend;
      pend = '0;
      if (ack != '0) begin
        got++;
        req   = req & ~ack;
        pend  = ack & armed;
        armed = armed & ~ack;
      end
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL ack_wait: got %0d acks, required %0d", got, n);
    end
    @(negedge clk);
  endtask

  // Monitor: start-pulse bookkeeping and scoreboard comparison on every ack.
  initial begin
    exp_t e;
    run = 0; low_run = 0; rise_cnt = 0; acks_seen = 0;
    ack_cyc = 0; done_cyc = 0; rise_cyc = 0; last_run = 0;
    forever begin
      @(negedge clk);
      if (div_done) done_cyc = cyc;
      if (div_start) begin
        if (run == 0) begin
          rise_cyc = cyc;
          rise_cnt++;
          low_runs.push_back(low_run);
        end
        run++;
        low_run = 0;
      end else begin
        if (run != 0) last_run = run;
        run = 0;
        low_run++;
      end
      if (ack != '0) begin
        ack_cyc = cyc;
        acks_seen++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got %b required none", ack);
        end else begin
          e = sb.pop_front();
          chk("ack_onehot", 32'(ack), 32'(1) << e.idx);
          chk("quotient", 32'(quot), 32'(e.q));
          chk("err", 32'(err), 32'(e.e));
        end
      end
    end
  end

  initial begin
    int t;
    int n0;
    rst  = 1'b0;
    req  = '0;
    dvd  = '0;
    dvs  = '0;
    hang = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(div_start), 0);
    chk("rst_quot", 32'(quot), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_dividend", div_dividend, 0);
    chk("rst_divisor", 32'(div_divisor), 0);
    rst = 1'b0;
    @(negedge clk);

    // All four at once from pointer 0.
    set_op(0, 32'h0036EE80, 16'd1000);
    set_op(1, 32'd100, 16'd7);
    set_op(2, 32'd196605, 16'd3);
    set_op(3, 32'h00123456, 16'h0100);
    expect_ack(0, 16'd3600, 1'b0);
    expect_ack(1, 16'd14, 1'b0);
    expect_ack(2, 16'hFFFF, 1'b0);
    expect_ack(3, 16'h1234, 1'b0);
    req = 4'b1111;
    run_acks(4, 4'b0000);
    for (int k = 1; k <= 3; k++)
      chk("start_low_gap", low_runs[low_runs.size()-k], 3);

    // Single request: start held LAT cycles, ack the cycle after done.
    expect_ack(0, 16'd3600, 1'b0);
    req[0] = 1'b1;
    run_acks(1, 4'b0000);
    chk("start_high_cycles", last_run, LAT);
    chk("ack_after_done", ack_cyc - done_cyc, 1);

    // Fairness: req1 re-requests right after its ack, req2 still goes first.
    expect_ack(1, 16'd14, 1'b0);
    expect_ack(2, 16'hFFFF, 1'b0);
    expect_ack(1, 16'd14, 1'b0);
    req[1] = 1'b1;
    req[2] = 1'b1;
    run_acks(3, 4'b0010);

    // Divider hangs: timeout answer, then normal service resumes.
    hang = 1'b1;
    set_op(2, 32'd1000, 16'd10);
    expect_ack(2, 16'hFFFF, 1'b1);
    req[2] = 1'b1;
    run_acks(1, 4'b0000);
    chk("timeout_start_cycles", last_run, TO);
    chk("timeout_ack_latency", ack_cyc - rise_cyc, TO);
    hang = 1'b0;
    expect_ack(3, 16'h1234, 1'b0);
    req[3] = 1'b1;
    run_acks(1, 4'b0000);

    // Advance pointer to 2, then reset in the middle of ISSUE.
    expect_ack(1, 16'd14, 1'b0);
    req[1] = 1'b1;
    run_acks(1, 4'b0000);
    hang = 1'b1;
    set_op(3, 32'd500, 16'd5);
    req[3] = 1'b1;
    t = 0;
    while (!div_start && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("start_before_reset", 32'(div_start), 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_start", 32'(div_start), 0);
    chk("async_rst_busy", 32'(busy), 0);
    req = '0;
    n0  = acks_seen;
    @(negedge clk);
    rst  = 1'b0;
    hang = 1'b0;
    repeat (6) @(negedge clk);
    chk("no_ack_after_reset", acks_seen - n0, 0);
    // Pointer back at 0: req1 must win over req2.
    expect_ack(1, 16'd14, 1'b0);
    expect_ack(2, 16'd100, 1'b0);
    req[1] = 1'b1;
    req[2] = 1'b1;
    run_acks(2, 4'b0000);

`ifdef DIV_ZERO_GUARD_EN
    n0 = rise_cnt;
    set_op(3, 32'd1234, 16'd0);
    expect_ack(3, 16'hFFFF, 1'b1);
    req[3] = 1'b1;
    run_acks(1, 4'b0000);
    chk("guard_no_start", rise_cnt, n0);
`endif

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
